// File: rtl/dma_boot_sequencer_if.sv
// DMA boot path bundle: UART byte stream in, shared UART transmitter, and the
// hub-side word pulses. The state field mirrors the sequencer FSM for checkers.
interface dma_boot_sequencer_if;
  // Handshake: rx_valid, tx_start, instr_ready and mem_ready are single-cycle
  // pulses with no backpressure; the payload (rdata, sdata, data) is valid in
  // the same cycle as its pulse. tx_busy is a level that holds off tx_start.
  logic        rx_valid;
  logic [7:0]  rdata;
  logic        tx_busy;
  logic        tx_start;
  logic [7:0]  sdata;
  logic        instr_ready;
  logic        mem_ready;
  logic [31:0] data;
  logic        program_loaded;
  logic        overflow;
  logic [1:0]  state;

  modport slave (
    input  rx_valid, rdata, tx_busy,
    output tx_start, sdata, instr_ready, mem_ready, data, program_loaded,
           overflow, state
  );

  modport master (
    output rx_valid, rdata, tx_busy,
    input  tx_start, sdata, instr_ready, mem_ready, data, program_loaded,
           overflow, state
  );
endinterface

// File: rtl/dma_boot_sequencer.sv
// Assembles UART bytes into little-endian words, loads the code segment as
// instruction pulses, sends one ack byte, then forwards run data as mem pulses.
module dma_boot_sequencer #(
  parameter int         CODE_WORDS_MAX = 256,
  parameter logic [7:0] ACK_BYTE       = 8'hAA
) (
  input  logic               clock,
  input  logic               reset,
  dma_boot_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    S_COUNT = 2'd0,
    S_LOAD  = 2'd1,
    S_ACK   = 2'd2,
    S_RUN   = 2'd3
  } state_t;

  localparam logic [31:0] CODE_MAX = 32'(CODE_WORDS_MAX);

  state_t      state;
  logic [1:0]  idx;
  logic [23:0] lanes;
  logic [31:0] remaining;
  logic [31:0] instr_idx;
  logic [31:0] data;
  logic [7:0]  sdata;
  logic        instr_ready;
  logic        mem_ready;
  logic        tx_start;
  logic        program_loaded;
  logic        overflow;

  logic        word_done;
  logic [31:0] word;

  // The top byte bypasses the lane register so the word is usable in cycle t.
  assign word_done = bus.rx_valid && (idx == 2'd3);
  assign word      = {bus.rdata, lanes};

  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= S_COUNT;
      idx            <= 2'd0;
      lanes          <= 24'd0;
      remaining      <= 32'd0;
      instr_idx      <= 32'd0;
      data           <= 32'd0;
      sdata          <= 8'd0;
      instr_ready    <= 1'b0;
      mem_ready      <= 1'b0;
      tx_start       <= 1'b0;
      program_loaded <= 1'b0;
      overflow       <= 1'b0;
    end else begin
      instr_ready <= 1'b0;
      mem_ready   <= 1'b0;
      tx_start    <= 1'b0;

      if (bus.rx_valid) begin
        idx <= idx + 2'd1;
        if (idx != 2'd3) lanes[{idx, 3'b000} +: 8] <= bus.rdata;
      end

      if (word_done) data <= word;

      case (state)
        S_COUNT: begin
          if (word_done) begin
            if (word == 32'd0) begin
              state <= S_ACK;
            end else begin
              remaining <= word;
              instr_idx <= 32'd0;
              state     <= S_LOAD;
            end
            if (word > CODE_MAX) overflow <= 1'b1;
          end
        end
        S_LOAD: begin
          // Words past the code segment are consumed but never written.
          if (word_done) begin
            remaining   <= remaining - 32'd1;
            instr_idx   <= instr_idx + 32'd1;
            instr_ready <= (instr_idx < CODE_MAX);
            if (remaining == 32'd1) state <= S_ACK;
          end
        end
        S_ACK: begin
          if (word_done) mem_ready <= 1'b1;
          if (!bus.tx_busy) begin
            tx_start <= 1'b1;
            sdata    <= ACK_BYTE;
            state    <= S_RUN;
          end
        end
        S_RUN: begin
          if (word_done) mem_ready <= 1'b1;
          program_loaded <= 1'b1;
        end
        default: state <= S_COUNT;
      endcase
    end
  end

  assign bus.state          = state;
  assign bus.data           = data;
  assign bus.sdata          = sdata;
  assign bus.instr_ready    = instr_ready;
  assign bus.mem_ready      = mem_ready;
  assign bus.tx_start       = tx_start;
  assign bus.program_loaded = program_loaded;
  assign bus.overflow       = overflow;

endmodule
